// File: rtl/program_loader.sv
// Boot-stage program loader: receives a length-prefixed byte stream, packs
// little-endian 32-bit words and writes them to instruction memory from 0.
// Signals prog_ready when the image is complete and tracks the PC's ack.
module program_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  load_start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_w_en,
    output logic [ADDR_WIDTH-1:0] imem_wr_addr,
    output logic [DATA_WIDTH-1:0] imem_data_in,
    output logic                  prog_ready,
    input  logic                  prog_ack,
    output logic                  busy,
    output logic                  load_error
);

    localparam int unsigned MAX_WORDS = MEM_DEPTH / 4;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StCollect,
        StWrite,
        StReady,
        StRun,
        StErr
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q;
    logic [15:0]           word_idx_q;
    logic [1:0]            byte_idx_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  xfer;
    logic                  restart;
    logic                  last_word;
    logic                  len_bad;
    logic [15:0]           len_full;

    assign xfer      = byte_valid && byte_ready;
    // load_start only counts when no load is in flight
    assign restart   = load_start &&
                       (state_q inside {StIdle, StReady, StRun, StErr});
    assign len_full  = {byte_data, len_q[7:0]};
    assign len_bad   = (len_full == 16'd0) || (len_full > 16'(MAX_WORDS));
    assign last_word = (word_idx_q == (len_q - 16'd1));

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (load_start) state_d = StLenLo;
            StLenLo:   if (xfer) state_d = StLenHi;
            StLenHi:   if (xfer) state_d = len_bad ? StErr : StCollect;
            StCollect: if (xfer && (byte_idx_q == 2'd3)) state_d = StWrite;
            StWrite:   state_d = last_word ? StReady : StCollect;
            StReady: begin
                if (load_start)    state_d = StLenLo;
                else if (prog_ack) state_d = StRun;
            end
            StRun:     if (load_start) state_d = StLenLo;
            StErr:     if (load_start) state_d = StLenLo;
            default:   state_d = StIdle;
        endcase
    end

    // Moore outputs decoded from state so reset clears them asynchronously
    always_comb begin
        byte_ready = 1'b0;
        imem_w_en  = 1'b0;
        prog_ready = 1'b0;
        busy       = 1'b0;
        load_error = 1'b0;
        unique case (state_q)
            StLenLo, StLenHi, StCollect: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
            end
            StWrite: begin
                imem_w_en = 1'b1;
                busy      = 1'b1;
            end
            StReady, StRun: prog_ready = 1'b1;
            StErr:          load_error = 1'b1;
            default: ;
        endcase
    end

    assign imem_wr_addr = addr_q;
    assign imem_data_in = data_q;

    // Length capture, byte packing and write-port registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else if (restart) begin
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            unique case (state_q)
                StLenLo: if (xfer) len_q[7:0] <= byte_data;
                StLenHi: begin
                    if (xfer) begin
                        len_q[15:8] <= byte_data;
                        word_idx_q  <= '0;
                        byte_idx_q  <= '0;
                    end
                end
                StCollect: begin
                    if (xfer) begin
                        word_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        // Latch the write port now so it is valid through WRITE
                        // and holds afterwards
                        if (byte_idx_q == 2'd3) begin
                            addr_q <= ADDR_WIDTH'({word_idx_q, 2'b00});
                            data_q <= {byte_data, word_q[23:0]};
                        end
                    end
                end
                StWrite: if (!last_word) word_idx_q <= word_idx_q + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned MEM_DEPTH  = 1024;

    logic                  clk        = 1'b0;
    logic                  arst_n     = 1'b0;
    logic                  load_start = 1'b0;
    logic                  byte_valid = 1'b0;
    logic [7:0]            byte_data  = '0;
    logic                  prog_ack   = 1'b0;
    logic                  byte_ready;
    logic                  imem_w_en;
    logic [ADDR_WIDTH-1:0] imem_wr_addr;
    logic [DATA_WIDTH-1:0] imem_data_in;
    logic                  prog_ready;
    logic                  busy;
    logic                  load_error;

    int unsigned err_cnt = 0;
    int unsigned chk_cnt = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        rdy_dropped;

    program_loader #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .load_start  (load_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .imem_w_en   (imem_w_en),
        .imem_wr_addr(imem_wr_addr),
        .imem_data_in(imem_data_in),
        .prog_ready  (prog_ready),
        .prog_ack    (prog_ack),
        .busy        (busy),
        .load_error  (load_error)
    );

    always #5 clk = ~clk;

    // Record every memory write seen in a write cycle
    always @(negedge clk) begin
        if (arst_n && imem_w_en) begin
            wr_addr_q.push_back(32'(imem_wr_addr));
            wr_data_q.push_back(imem_data_in);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("byte_ready_timeout", {31'b0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // stall>0: hold byte_valid low for that many cycles after each byte
    task automatic send_word(input logic [31:0] w, input int stall);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8]);
            for (int s = 0; s < stall; s++) begin
                if (k != 3 && !byte_ready) rdy_dropped = 1'b1;
                @(negedge clk);
            end
        end
    endtask

    task automatic send_len(input logic [15:0] len);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic pulse_ack();
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'd0);
        check({tag, "_w_en"},       {31'b0, imem_w_en},  32'd0);
        check({tag, "_addr"},       32'(imem_wr_addr),   32'd0);
        check({tag, "_data"},       imem_data_in,        32'd0);
        check({tag, "_prog_ready"}, {31'b0, prog_ready}, 32'd0);
        check({tag, "_busy"},       {31'b0, busy},       32'd0);
        check({tag, "_load_error"}, {31'b0, load_error}, 32'd0);
    endtask

    initial begin
        logic [31:0] w;

        // Reset
        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        arst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle");

        // 1. Basic two-word load with latency checks
        pulse_start();
        check("t1_busy", {31'b0, busy}, 32'd1);
        check("t1_rdy_lenlo", {31'b0, byte_ready}, 32'd1);
        send_len(16'd2);
        send_word(32'h00A00513, 0);
        check("t1_w0_en", {31'b0, imem_w_en}, 32'd1);
        check("t1_w0_addr", 32'(imem_wr_addr), 32'h000);
        check("t1_w0_data", imem_data_in, 32'h00A00513);
        check("t1_w0_rdy_low", {31'b0, byte_ready}, 32'd0);
        send_word(32'h00100593, 0);
        check("t1_w1_en", {31'b0, imem_w_en}, 32'd1);
        check("t1_w1_addr", 32'(imem_wr_addr), 32'h004);
        check("t1_w1_data", imem_data_in, 32'h00100593);
        check("t1_pr_early", {31'b0, prog_ready}, 32'd0);
        @(negedge clk);
        check("t1_pr", {31'b0, prog_ready}, 32'd1);
        check("t1_w_en_off", {31'b0, imem_w_en}, 32'd0);
        check("t1_busy_off", {31'b0, busy}, 32'd0);
        check("t1_addr_hold", 32'(imem_wr_addr), 32'h004);
        check("t1_data_hold", imem_data_in, 32'h00100593);
        @(negedge clk);
        check("t1_nwr", wr_addr_q.size(), 32'd2);
        check("t1_log_a1", wr_addr_q[1], 32'h004);
        check("t1_log_d0", wr_data_q[0], 32'h00A00513);
        check("t1_pr_stays", {31'b0, prog_ready}, 32'd1);

        // 2. Same stream with 1-0-0 valid pattern
        clear_log();
        rdy_dropped = 1'b0;
        pulse_start();
        check("t2_pr_cleared", {31'b0, prog_ready}, 32'd0);
        send_len(16'd2);
        send_word(32'h00A00513, 2);
        send_word(32'h00100593, 2);
        check("t2_rdy_held", {31'b0, rdy_dropped}, 32'd0);
        check("t2_pr", {31'b0, prog_ready}, 32'd1);
        check("t2_nwr", wr_addr_q.size(), 32'd2);
        check("t2_a0", wr_addr_q[0], 32'h000);
        check("t2_d0", wr_data_q[0], 32'h00A00513);
        check("t2_a1", wr_addr_q[1], 32'h004);
        check("t2_d1", wr_data_q[1], 32'h00100593);

        // 3. Illegal lengths, then the largest legal image, then recovery
        clear_log();
        pulse_start();
        send_len(16'h0000);
        check("t3_len0_err", {31'b0, load_error}, 32'd1);
        check("t3_len0_busy", {31'b0, busy}, 32'd0);
        check("t3_len0_rdy", {31'b0, byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("t3_err_sticky", {31'b0, load_error}, 32'd1);
        pulse_start();
        check("t3_err_clr", {31'b0, load_error}, 32'd0);
        check("t3_restart_busy", {31'b0, busy}, 32'd1);
        send_len(16'h0101);
        check("t3_len257_err", {31'b0, load_error}, 32'd1);
        @(negedge clk);
        check("t3_no_writes", wr_addr_q.size(), 32'd0);

        pulse_start();
        send_len(16'd256);
        check("t3_len256_ok", {31'b0, load_error}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            w = {8'hC0, 8'(i), 8'(255 - i), 8'h5A};
            send_word(w, 0);
        end
        @(negedge clk);
        check("t3_max_pr", {31'b0, prog_ready}, 32'd1);
        check("t3_max_nwr", wr_addr_q.size(), 32'd256);
        check("t3_max_a100", wr_addr_q[100], 32'h190);
        check("t3_max_d100", wr_data_q[100], 32'hC0649B5A);
        check("t3_max_alast", wr_addr_q[255], 32'h3FC);
        check("t3_max_dlast", wr_data_q[255], 32'hC0FF005A);

        clear_log();
        pulse_start();
        send_len(16'd1);
        send_word(32'h12345678, 0);
        @(negedge clk);
        check("t3_rec_pr", {31'b0, prog_ready}, 32'd1);
        check("t3_rec_err", {31'b0, load_error}, 32'd0);
        check("t3_rec_nwr", wr_addr_q.size(), 32'd1);
        check("t3_rec_a", wr_addr_q[0], 32'h000);
        check("t3_rec_d", wr_data_q[0], 32'h12345678);

        // 4. READY -> RUN, then restart from RUN
        pulse_ack();
        check("t4_run_pr", {31'b0, prog_ready}, 32'd1);
        repeat (2) @(negedge clk);
        check("t4_run_pr_hold", {31'b0, prog_ready}, 32'd1);
        check("t4_run_busy", {31'b0, busy}, 32'd0);
        pulse_start();
        check("t4_pr_drop", {31'b0, prog_ready}, 32'd0);
        check("t4_busy", {31'b0, busy}, 32'd1);

        // 5. Reset during the second of three writes
        clear_log();
        send_len(16'd3);
        send_word(32'hDEADBEEF, 0);
        send_word(32'hCAFEF00D, 0);
        check("t5_pre_w_en", {31'b0, imem_w_en}, 32'd1);
        #2 arst_n = 1'b0;
        #1 check_outputs_zero("t5_arst");
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        check("t5_idle_busy", {31'b0, busy}, 32'd0);
        clear_log();
        pulse_start();
        send_len(16'd1);
        send_word(32'hA5A51234, 0);
        @(negedge clk);
        check("t5_nwr", wr_addr_q.size(), 32'd1);
        check("t5_a", wr_addr_q[0], 32'h000);
        check("t5_d", wr_data_q[0], 32'hA5A51234);
        check("t5_pr", {31'b0, prog_ready}, 32'd1);

        // 6. load_start mid-COLLECT is ignored
        clear_log();
        pulse_start();
        send_len(16'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        check("t6_busy", {31'b0, busy}, 32'd1);
        check("t6_rdy", {31'b0, byte_ready}, 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        send_word(32'h88776655, 0);
        @(negedge clk);
        check("t6_pr", {31'b0, prog_ready}, 32'd1);
        check("t6_nwr", wr_addr_q.size(), 32'd2);
        check("t6_a0", wr_addr_q[0], 32'h000);
        check("t6_d0", wr_data_q[0], 32'h44332211);
        check("t6_a1", wr_addr_q[1], 32'h004);
        check("t6_d1", wr_data_q[1], 32'h88776655);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
